hangman_engine: RTL

// - Parametrised single-player hangman game core. Replaces the fixed 4-letter control/datapath pair.
// - Holds a loaded word of up to WORD_LEN letters and accepts one committed guess per go press/release.
// - Tracks which letter positions are revealed, wrong-guess count, already-used letters and a

---
 rtl/hangman_pkg.sv | 15 +
 rtl/hangman_if.sv | 38 +++
 rtl/hangman_engine_sec_timer.sv | 59 +++++
 rtl/hangman_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and state encoding for the hangman game core.
package hangman_pkg;

   localparam int LETTER_W   = 5;
   localparam int ALPHA_SIZE = 26;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WON   = 3'd3,
      ST_LOST  = 3'd4
   } state_t;

endpackage

// File: rtl/hangman_if.sv
// Board-side bundle of the hangman core: word/guess controls in, game status out.
interface hangman_if #(
   parameter int WORD_LEN   = 4,
   parameter int LETTER_W   = hangman_pkg::LETTER_W,
   parameter int MAX_WRONG  = 8,
   parameter int TIME_LIMIT = 60
);
   localparam int WL_W  = $clog2(WORD_LEN + 1);
   localparam int CNT_W = $clog2(MAX_WRONG + 1);
   localparam int SEC_W = $clog2(TIME_LIMIT + 1);

   logic                         load;
   logic [WORD_LEN*LETTER_W-1:0] word;
   logic [WL_W-1:0]              word_len;
   logic [LETTER_W-1:0]          guess;
   logic                         go;
   logic [WORD_LEN-1:0]          revealed;
   logic [CNT_W-1:0]             wrong_count;
   logic [CNT_W-1:0]             guesses_left;
   logic [SEC_W-1:0]             secs_left;
   logic                         playing;
   logic                         won;
   logic                         lost;
   logic                         hit;
   logic                         miss;
   logic                         rpt;

   modport master (
      output load, word, word_len, guess, go,
      input  revealed, wrong_count, guesses_left, secs_left, playing, won, lost, hit, miss, rpt
   );

   modport slave (
      input  load, word, word_len, guess, go,
      output revealed, wrong_count, guesses_left, secs_left, playing, won, lost, hit, miss, rpt
   );

endinterface

// File: rtl/hangman_engine_sec_timer.sv
// Game clock: divides clk into seconds and counts the remaining game time down to zero.
module sec_timer #(
   parameter int  TICKS_PER_SEC = 50_000_000,
   parameter int  TIME_LIMIT    = 60,
   localparam int SEC_W         = $clog2(TIME_LIMIT + 1),
   localparam int TICK_W        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             run,
   output logic [SEC_W-1:0] secs_left,
   output logic             expired
);

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [SEC_W-1:0]  secs_q, secs_d;
   logic              wrap;

   // Next tick/second values; expired strobes on the tick that takes the count to zero.
   always_comb begin
      wrap    = run && (tick_q == TICK_W'(TICKS_PER_SEC - 1));
      tick_d  = tick_q;
      secs_d  = secs_q;
      expired = 1'b0;
      if (restart) begin
         tick_d = '0;
         secs_d = SEC_W'(TIME_LIMIT);
      end else begin
         if (wrap) begin
            tick_d = '0;
         end else if (run) begin
            tick_d = tick_q + TICK_W'(1);
         end else begin
            tick_d = tick_q;
         end
         if (wrap && (secs_q != '0)) begin
            secs_d = secs_q - SEC_W'(1);
         end else begin
            secs_d = secs_q;
         end
         expired = wrap && (secs_q == SEC_W'(1));
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q <= '0;
         secs_q <= SEC_W'(TIME_LIMIT);
      end else begin
         tick_q <= tick_d;
         secs_q <= secs_d;
      end
   end

   assign secs_left = secs_q;

endmodule

// File: rtl/hangman_engine.sv
// Single-player hangman core: holds the word, judges committed guesses, tracks
// misses, used letters and the game clock, and resolves each game to WON or LOST.
module hangman_engine #(
   parameter int WORD_LEN      = 4,
   parameter int LETTER_W      = hangman_pkg::LETTER_W,
   parameter int MAX_WRONG     = 8,
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int TIME_LIMIT    = 60
) (
   input logic      clk,
   input logic      reset,
   hangman_if.slave bus
);
   import hangman_pkg::*;

   localparam int WL_W  = $clog2(WORD_LEN + 1);
   localparam int CNT_W = $clog2(MAX_WRONG + 1);
   localparam int SEC_W = $clog2(TIME_LIMIT + 1);

   state_t                       state_q, state_d;
   logic [WORD_LEN*LETTER_W-1:0] word_q, word_d;
   logic [WORD_LEN-1:0]          active_q, active_d;
   logic [WORD_LEN-1:0]          revealed_q, revealed_d;
   logic [CNT_W-1:0]             wrong_q, wrong_d;
   logic [CNT_W-1:0]             left_q, left_d;
   logic [ALPHA_SIZE-1:0]        used_q, used_d;
   logic [LETTER_W-1:0]          guess_q, guess_d;
   logic                         go_q, go_d;
   logic                         hit_q, hit_d;
   logic                         miss_q, miss_d;
   logic                         rpt_q, rpt_d;
   logic                         playing_q, playing_d;
   logic                         won_q, won_d;
   logic                         lost_q, lost_d;

   logic [WL_W-1:0]              len_clamped;
   logic [WORD_LEN-1:0]          load_active;
   logic [WORD_LEN-1:0]          match;
   logic                         guess_valid;
   logic                         commit;
   logic                         timer_run;
   logic                         timer_expired;
   logic [SEC_W-1:0]             secs_left;

   assign commit    = go_q && !bus.go;
   assign timer_run = (state_q == ST_PLAY) || (state_q == ST_CHECK);

   sec_timer #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .TIME_LIMIT    (TIME_LIMIT)
   ) u_sec_timer (
      .clk       (clk),
      .reset     (reset),
      .restart   (bus.load),
      .run       (timer_run),
      .secs_left (secs_left),
      .expired   (timer_expired)
   );

   // Word-length clamp, active-position mask for a new word, and letter matches for the held guess.
   always_comb begin
      if ((bus.word_len == '0) || (bus.word_len > WL_W'(WORD_LEN))) begin
         len_clamped = WL_W'(WORD_LEN);
      end else begin
         len_clamped = bus.word_len;
      end
      load_active = '0;
      match       = '0;
      for (int i = 0; i < WORD_LEN; i++) begin
         load_active[i] = (WL_W'(i) < len_clamped);
         match[i]       = active_q[i] && (word_q[i*LETTER_W +: LETTER_W] == guess_q);
      end
      guess_valid = (guess_q <= LETTER_W'(ALPHA_SIZE - 1));
   end

   // Next-state and datapath updates; a load overrides whatever the FSM would do this cycle.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      active_d   = active_q;
      revealed_d = revealed_q;
      wrong_d    = wrong_q;
      used_d     = used_q;
      guess_d    = guess_q;
      go_d       = bus.go;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      rpt_d      = 1'b0;
      if (bus.load) begin
         state_d    = ST_PLAY;
         word_d     = bus.word;
         active_d   = load_active;
         revealed_d = ~load_active;
         wrong_d    = '0;
         used_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_PLAY: begin
               if (timer_expired) begin
                  state_d = ST_LOST;
               end else if (commit) begin
                  state_d = ST_CHECK;
                  guess_d = bus.guess;
               end else begin
                  state_d = ST_PLAY;
               end
            end
            ST_CHECK: begin
               if (guess_valid && !used_q[guess_q]) begin
                  used_d[guess_q] = 1'b1;
                  if (match != '0) begin
                     revealed_d = revealed_q | match;
                     hit_d      = 1'b1;
                  end else if (wrong_q != CNT_W'(MAX_WRONG)) begin
                     wrong_d = wrong_q + CNT_W'(1);
                     miss_d  = 1'b1;
                  end else begin
                     miss_d = 1'b1;
                  end
               end else begin
                  // An out-of-alphabet code is dropped silently; only a genuine repeat pulses.
                  rpt_d = guess_valid;
               end
               // A win takes precedence over a timer expiry landing in the same cycle.
               if (&revealed_d) begin
                  state_d = ST_WON;
               end else if ((wrong_d == CNT_W'(MAX_WRONG)) || timer_expired) begin
                  state_d = ST_LOST;
               end else begin
                  state_d = ST_PLAY;
               end
            end
            ST_WON:  state_d = ST_WON;
            ST_LOST: state_d = ST_LOST;
            default: state_d = ST_IDLE;
         endcase
      end
      left_d    = CNT_W'(MAX_WRONG) - wrong_d;
      playing_d = (state_d == ST_PLAY) || (state_d == ST_CHECK);
      won_d     = (state_d == ST_WON);
      lost_d    = (state_d == ST_LOST);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         active_q   <= '0;
         revealed_q <= '0;
         wrong_q    <= '0;
         left_q     <= CNT_W'(MAX_WRONG);
         used_q     <= '0;
         guess_q    <= '0;
         go_q       <= 1'b0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         rpt_q      <= 1'b0;
         playing_q  <= 1'b0;
         won_q      <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         active_q   <= active_d;
         revealed_q <= revealed_d;
         wrong_q    <= wrong_d;
         left_q     <= left_d;
         used_q     <= used_d;
         guess_q    <= guess_d;
         go_q       <= go_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         rpt_q      <= rpt_d;
         playing_q  <= playing_d;
         won_q      <= won_d;
         lost_q     <= lost_d;
      end
   end

   assign bus.revealed     = revealed_q;
   assign bus.wrong_count  = wrong_q;
   assign bus.guesses_left = left_q;
   assign bus.secs_left    = secs_left;
   assign bus.playing      = playing_q;
   assign bus.won          = won_q;
   assign bus.lost         = lost_q;
   assign bus.hit          = hit_q;
   assign bus.miss         = miss_q;
   assign bus.rpt          = rpt_q;

endmodule
